// File: rtl/datapath.sv
// datapath: register file, A/B operands, shifter, ALU, result register C and {Z,N,V} status.
// Every select and enable is driven each cycle by the controller; outputs are purely registered.
module datapath (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  readnum,
   input  logic [1:0]  vsel,
   input  logic        loada,
   input  logic        loadb,
   input  logic [1:0]  shift,
   input  logic        asel,
   input  logic        bsel,
   input  logic [1:0]  ALUop,
   input  logic        loadc,
   input  logic        loads,
   input  logic [2:0]  writenum,
   input  logic        write,
   input  logic [15:0] sximm5,
   input  logic [15:0] mdata,
   input  logic [15:0] sximm8,
   input  logic [7:0]  PC,
   output logic [15:0] datapath_out,
   output logic        N_out,
   output logic        V_out,
   output logic        Z_out
);
   logic [15:0] r_q [8];
   logic [15:0] r_d [8];
   logic [15:0] a_q, a_d, b_q, b_d, c_q, c_d;
   logic [2:0]  status_q, status_d;
   logic [15:0] data_out, wb_data, b_sh, ain, bin, res;
   logic        ovf;
   always_comb begin
      data_out = r_q[readnum];
      wb_data  = vsel == 2'd0 ? c_q :
                 vsel == 2'd1 ? {8'b0, PC} :
                 vsel == 2'd2 ? sximm8 : mdata;
      b_sh     = shift == 2'd0 ? b_q :
                 shift == 2'd1 ? {b_q[14:0], 1'b0} :
                 shift == 2'd2 ? {1'b0, b_q[15:1]} : {b_q[15], b_q[15:1]};
      ain      = asel ? 16'b0 : a_q;
      bin      = bsel ? sximm5 : b_sh;
      res      = ALUop == 2'd0 ? ain + bin :
                 ALUop == 2'd1 ? ain - bin :
                 ALUop == 2'd2 ? ain & bin : ~bin;
      // Overflow only has meaning for add/sub; the logic ops never overflow.
      ovf      = ALUop == 2'd0 ? (ain[15] == bin[15]) && (res[15] != ain[15]) :
                 ALUop == 2'd1 ? (ain[15] != bin[15]) && (res[15] != ain[15]) : 1'b0;
      r_d      = r_q;
      if (write) r_d[writenum] = wb_data;
      a_d      = loada ? data_out : a_q;
      b_d      = loadb ? data_out : b_q;
      c_d      = loadc ? res : c_q;
      status_d = loads ? {res == 16'b0, res[15], ovf} : status_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q      <= '{default: '0};
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         status_q <= '0;
      end else begin
         r_q      <= r_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         status_q <= status_d;
      end
   end
   assign datapath_out = c_q;
   assign Z_out        = status_q[2];
   assign N_out        = status_q[1];
   assign V_out        = status_q[0];
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed vectors; expectations queued at issue time, checked by an independent monitor.
module tb_datapath;
   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  readnum, writenum;
   logic [1:0]  vsel, shift, ALUop;
   logic        loada, loadb, asel, bsel, loadc, loads, write;
   logic [15:0] sximm5, mdata, sximm8;
   logic [7:0]  PC;
   logic [15:0] datapath_out;
   logic        N_out, V_out, Z_out;
   typedef struct {
      string       name;
      logic [15:0] c;
      logic        n, v, z;
   } exp_t;
   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;
   always #5 clk = ~clk;
   datapath dut (
      .clk(clk), .reset(reset), .readnum(readnum), .vsel(vsel), .loada(loada), .loadb(loadb),
      .shift(shift), .asel(asel), .bsel(bsel), .ALUop(ALUop), .loadc(loadc), .loads(loads),
      .writenum(writenum), .write(write), .sximm5(sximm5), .mdata(mdata), .sximm8(sximm8),
      .PC(PC), .datapath_out(datapath_out), .N_out(N_out), .V_out(V_out), .Z_out(Z_out)
   );
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_vec++;
         if (datapath_out !== e.c || N_out !== e.n || V_out !== e.v || Z_out !== e.z) begin
            n_bad++;
            $display("FAIL %s: got out=%h N=%b V=%b Z=%b, want out=%h N=%b V=%b Z=%b",
                     e.name, datapath_out, N_out, V_out, Z_out, e.c, e.n, e.v, e.z);
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [15:0] c, input logic n, input logic v, input logic z);
      exp_t e;
      e.name = name; e.c = c; e.n = n; e.v = v; e.z = z;
      sb.push_back(e);
   endtask
   // Unselected write-back sources carry the complement so a wrong vsel decode is visible.
   task automatic wr(input logic [2:0] n, input logic [1:0] vs, input logic [15:0] val);
      vsel = vs; writenum = n; write = 1'b1;
      sximm8 = vs == 2'd2 ? val : ~val;
      mdata  = vs == 2'd3 ? val : ~val;
      PC     = vs == 2'd1 ? val[7:0] : ~val[7:0];
      tick();
      write = 1'b0;
   endtask
   task automatic lda(input logic [2:0] n);
      readnum = n; loada = 1'b1;
      tick();
      loada = 1'b0;
   endtask
   task automatic ldb(input logic [2:0] n);
      readnum = n; loadb = 1'b1;
      tick();
      loadb = 1'b0;
   endtask
   task automatic alu(input logic [1:0] sh, input logic as, input logic bs, input logic [1:0] op,
                      input logic lc, input logic ls, input logic [15:0] imm5);
      shift = sh; asel = as; bsel = bs; ALUop = op; loadc = lc; loads = ls; sximm5 = imm5;
      tick();
      loadc = 1'b0; loads = 1'b0;
   endtask
   initial begin
      {readnum, writenum, vsel, shift, ALUop} = '0;
      {loada, loadb, asel, bsel, loadc, loads, write} = '0;
      sximm5 = '0; mdata = '0; sximm8 = '0; PC = '0;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      chk("reset", 16'h0000, 0, 0, 0);
      wr(3, 2, 16'd169); wr(4, 2, 16'd100); lda(3); ldb(4);
      alu(0, 0, 0, 1, 1, 0, 0);
      chk("sub", 16'h0045, 0, 0, 0);
      wr(5, 0, 16'h0000); lda(5);
      alu(0, 0, 1, 0, 1, 0, 0);
      chk("c_to_r5", 16'h0045, 0, 0, 0);
      wr(0, 2, 16'd7); wr(1, 2, 16'd2); ldb(0); lda(1);
      alu(1, 0, 0, 0, 1, 0, 0);
      chk("shl_add", 16'd16, 0, 0, 0);
      wr(2, 0, 16'h0000); lda(2);
      alu(0, 0, 1, 0, 1, 0, 0);
      chk("c_to_r2", 16'd16, 0, 0, 0);
      lda(1);
      alu(0, 0, 0, 1, 1, 1, 0);
      chk("neg", 16'hFFFB, 1, 0, 0);
      wr(0, 2, 16'h7FFF); ldb(0);
      alu(0, 0, 0, 0, 1, 1, 0);
      chk("add_ovf", 16'h8001, 1, 1, 0);
      ldb(1);
      alu(0, 0, 0, 1, 1, 1, 0);
      chk("zero", 16'h0000, 0, 0, 1);
      alu(0, 1, 1, 0, 1, 1, 16'd5);
      chk("imm_mux", 16'h0005, 0, 0, 0);
      wr(6, 2, 16'h00FF); ldb(6);
      alu(0, 0, 0, 3, 1, 1, 0);
      chk("not", 16'hFF00, 1, 0, 0);
      wr(7, 2, 16'h0FF0); lda(7);
      alu(0, 0, 0, 2, 1, 1, 0);
      chk("and", 16'h00F0, 0, 0, 0);
      wr(7, 1, 16'hFFAB); lda(7);
      alu(0, 0, 1, 0, 1, 0, 0);
      chk("pc_wb", 16'h00AB, 0, 0, 0);
      wr(5, 3, 16'h1234); lda(5);
      alu(0, 0, 1, 0, 1, 0, 0);
      chk("mdata_wb", 16'h1234, 0, 0, 0);
      readnum = 1; loada = 1'b1; writenum = 1; write = 1'b1; vsel = 2; sximm8 = 16'h0055;
      tick();
      loada = 1'b0; write = 1'b0;
      alu(0, 0, 1, 0, 1, 0, 0);
      chk("rw_same_old", 16'h0002, 0, 0, 0);
      lda(1);
      alu(0, 0, 1, 0, 1, 0, 0);
      chk("rw_same_new", 16'h0055, 0, 0, 0);
      shift = 0; asel = 0; bsel = 0; ALUop = 1; loadc = 1'b1; vsel = 0; writenum = 4; write = 1'b1;
      tick();
      loadc = 1'b0; write = 1'b0;
      chk("c_same_edge", 16'hFF56, 0, 0, 0);
      lda(4);
      alu(0, 0, 1, 0, 1, 0, 0);
      chk("c_old_written", 16'h0055, 0, 0, 0);
      wr(2, 2, 16'h8002); ldb(2);
      alu(2, 1, 0, 0, 1, 1, 0);
      chk("lsr", 16'h4001, 0, 0, 0);
      alu(3, 1, 0, 0, 1, 1, 0);
      chk("asr", 16'hC001, 1, 0, 0);
      wr(3, 2, 16'h8000); lda(3); wr(3, 2, 16'h0001); ldb(3);
      alu(0, 0, 0, 1, 1, 1, 0);
      chk("sub_ovf", 16'h7FFF, 0, 1, 0);
      alu(0, 0, 0, 0, 0, 1, 0);
      chk("loads_only", 16'h7FFF, 1, 0, 0);
      alu(0, 1, 1, 0, 1, 0, 0);
      chk("loadc_only", 16'h0000, 1, 0, 0);
      alu(0, 0, 0, 0, 1, 1, 0);
      chk("pre_reset", 16'h8001, 1, 0, 0);
      reset = 1'b1; loadc = 1'b1; loads = 1'b1; write = 1'b1; loada = 1'b1; loadb = 1'b1;
      tick();
      reset = 1'b0; loadc = 1'b0; loads = 1'b0; write = 1'b0; loada = 1'b0; loadb = 1'b0;
      chk("mid_reset", 16'h0000, 0, 0, 0);
      alu(0, 0, 0, 0, 1, 1, 0);
      chk("rst_ab", 16'h0000, 0, 0, 1);
      alu(0, 1, 1, 0, 1, 0, 16'd5);
      chk("post_rst_imm", 16'h0005, 0, 0, 1);
      lda(3); ldb(4);
      alu(0, 0, 0, 0, 1, 0, 0);
      chk("rst_regs", 16'h0000, 0, 0, 1);
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/datapath.md
# datapath

Datapath for the simple RISC machine. It contains an 8-entry × 16-bit register file, A/B operand registers, a barrel shifter, operand source muxes, a 4-function ALU, a result register C and a 3-bit status register (Z, N, V). It sits under the controller FSM, which drives every select and load-enable each cycle. The only outputs are the registered result and the status flags.

## Interface
- No parameters; all widths fixed at 16-bit data, 3-bit register index.
- clk  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high; clears all state.
- readnum  in  3  register-file read index.
- vsel  in  2  write-back source: 00 = C, 01 = {8'b0, PC}, 10 = sximm8, 11 = mdata.
- loada  in  1  load A from the register-file read port.
- loadb  in  1  load B from the register-file read port.
- shift  in  2  shifter op on B: 00 pass, 01 shl 1, 10 logical shr 1, 11 arithmetic shr 1.
- asel  in  1  1 = ALU A input is 16'b0; 0 = register A.
- bsel  in  1  1 = ALU B input is sximm5; 0 = shifter output.
- ALUop  in  2  00 add, 01 A−B, 10 A&B, 11 ~B.
- loadc  in  1  load C from the ALU result.
- loads  in  1  load status {Z,N,V} from the ALU flags.
- writenum  in  3  register-file write index.
- write  in  1  register-file write enable.
- sximm5  in  16  sign-extended 5-bit immediate.
- mdata  in  16  memory read data.
- sximm8  in  16  sign-extended 8-bit immediate.
- PC  in  8  program counter; zero-extended for write-back.
- datapath_out  out  16  contents of C.
- N_out  out  1  status N.
- V_out  out  1  status V.
- Z_out  out  1  status Z.
- Positional port order after clk/reset: readnum, vsel, loada, loadb, shift, asel, bsel, ALUop, loadc, loads, writenum, write, sximm5, mdata, sximm8, PC, datapath_out, N_out, V_out, Z_out.

## Operation
- **Register file.** 8 × 16 bits. Read is combinational: `data_out = R[readnum]`. Write happens on the clock edge when `write=1`: `R[writenum] <= vsel-mux output`.
- **Operand registers.** A and B each load `data_out` on the edge when their load enable is 1; otherwise they hold.
- **Shifter.** Operates on B only.
  - 01: `{B[14:0],0}`
  - 10: `{0,B[15:1]}`
  - 11: `{B[15],B[15:1]}`
- **ALU.** Operates modulo 2^16 on Ain and Bin.
- **Flags** (computed from the ALU result):
  - Z = result==0.
  - N = result[15].
  - V for add: `Ain[15]==Bin[15] && res[15]!=Ain[15]`.
  - V for subtract: `Ain[15]!=Bin[15] && res[15]!=Ain[15]`.
  - V for AND and NOT: 0.
- **C / status.** C loads the ALU result when `loadc=1`. The status register loads {Z,N,V} when `loads=1`. loadc and loads are independent.
- **Outputs.** `datapath_out` = C. N_out, V_out and Z_out come straight from the status register.
- **Reset.** Clears R0–R7, A, B, C and status to 0. Reset has priority over all load and write enables.

## Timing
- All state updates on the rising edge of clk; there is no handshake.
- **Write-back.** A write of `sximm8`, `mdata` or `PC` lands in R[writenum] one edge after the controls are presented.
- **Read-through.** Read data is combinational, so A or B loaded on edge k+1 sees a value written on edge k.
- **Same-edge read/write.** Write to Rn while loading A/B from Rn on the same edge: A/B capture the old Rn value.
- **C write-back timing.** `vsel=00` with `write=1` on the same edge as `loadc=1` writes the old C; the new C is written one edge later.
- **Latency from loaded operands.** With A and B already loaded, the result appears on `datapath_out` one edge after loadc. Flags appear one edge after loads.
- **Reset timing.** Reset is sampled at the edge. All outputs read 0 after that edge, including mid-sequence.

## Test plan
- **Subtract.** R3←169, R4←100 via vsel=10. Load A←R3, B←R4, shift=00, ALUop=01, asel=bsel=0, loadc. Write C→R5 with vsel=00 → `datapath_out` = 69 (0x0045).
- **Shift then add.** R0←7, R1←2. B←R0, A←R1, shift=01, ALUop=00, loadc → `datapath_out` = 16; R2 receives 16.
- **Negative flag.** B=7, A=2, shift=00, ALUop=01, loadc+loads → result 0xFFFB; N_out=1, Z_out=0, V_out=0.
- **Overflow flag.** R0←0x7FFF, R1←2. B←R0, A←R1, ALUop=00, loads → result 0x8001; V_out=1, N_out=1.
- **Zero flag.** B=2, A=2, ALUop=01, loadc+loads → `datapath_out` = 0, Z_out=1, N_out=0, V_out=0.
- **Muxes, remaining ops, reset.**
  - asel=1, bsel=1, sximm5=5, ALUop=00 → C=5.
  - ALUop=11 with B=0x00FF → C=0xFF00.
  - ALUop=10 → C = A&B.
  - vsel=01 with PC=0xAB → R = 0x00AB.
  - Asserting reset → all outputs 0 and registers 0 next edge.
